// File: rtl/pll_post_scaler_bank.sv
// N-channel post-scaler bank on the PLL output clock: per-channel shadowed config,
// boundary-aligned glitch-free reconfiguration, phase SYNC and status outputs.
module pll_post_scaler_bank #(
    parameter int NCH = 2,
    parameter int L2W = 8,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CK,
    input  logic           RST,
    input  logic           CFG_WE,
    input  logic [CHW-1:0] CFG_CH,
    input  logic           CFG_EN,
    input  logic           CFG_BYPASS,
    input  logic [1:0]     CFG_L1,
    input  logic [L2W-1:0] CFG_L2,
    input  logic           SYNC,
    output logic [NCH-1:0] CK_DIV,
    output logic [NCH-1:0] CK_TICK,
    output logic [NCH-1:0] BYPASS_SEL,
    output logic [NCH-1:0] CFG_PENDING,
    output logic [NCH-1:0] RUNNING
);
    localparam int CW = L2W + 3;

    logic [NCH-1:0] sh_en, sh_byp, act_en, act_byp, pend, div_q, tick_q;
    logic [1:0]     sh_l1   [NCH];
    logic [1:0]     act_l1  [NCH];
    logic [L2W-1:0] sh_l2   [NCH];
    logic [L2W-1:0] act_l2  [NCH];
    logic [L2W-1:0] l2_eff  [NCH];
    logic [CW-1:0]  cnt     [NCH];
    logic [CW-1:0]  cnt_nxt [NCH];
    logic [CW-1:0]  div_d   [NCH];
    logic [CW-1:0]  half    [NCH];
    logic [NCH-1:0] run, term, apply, wr_sel;

    assign run = act_en & ~act_byp;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            l2_eff[i]  = (act_l2[i] == '0) ? L2W'(1) : act_l2[i];
            div_d[i]   = CW'(l2_eff[i]) << act_l1[i];
            half[i]    = (div_d[i] + CW'(1)) >> 1;
            term[i]    = (cnt[i] == div_d[i] - CW'(1));
            // SYNC outranks the terminal count; both restart the period
            cnt_nxt[i] = (SYNC || term[i]) ? '0 : cnt[i] + CW'(1);
            // A running channel only swaps config at a period boundary or SYNC
            apply[i]   = pend[i] & (~run[i] | term[i] | SYNC);
            // Out-of-range channel indices match no channel and are dropped
            wr_sel[i]  = CFG_WE && (CFG_CH == CHW'(i));
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            sh_en   <= '0;
            sh_byp  <= '0;
            act_en  <= '0;
            act_byp <= '0;
            pend    <= '0;
            div_q   <= '0;
            tick_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                sh_l1[i]  <= '0;
                sh_l2[i]  <= '0;
                act_l1[i] <= '0;
                act_l2[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // A write in the apply cycle lands in the shadow after the old one is consumed
                if (wr_sel[i]) begin
                    sh_en[i]  <= CFG_EN;
                    sh_byp[i] <= CFG_BYPASS;
                    sh_l1[i]  <= CFG_L1;
                    sh_l2[i]  <= CFG_L2;
                    pend[i]   <= 1'b1;
                end else if (apply[i]) begin
                    pend[i]   <= 1'b0;
                end

                if (apply[i]) begin
                    act_en[i]  <= sh_en[i];
                    act_byp[i] <= sh_byp[i];
                    act_l1[i]  <= sh_l1[i];
                    act_l2[i]  <= sh_l2[i];
                    cnt[i]     <= '0;
                    div_q[i]   <= sh_en[i] & ~sh_byp[i];
                    tick_q[i]  <= sh_en[i] & ~sh_byp[i];
                end else if (run[i]) begin
                    cnt[i]     <= cnt_nxt[i];
                    div_q[i]   <= (cnt_nxt[i] < half[i]);
                    tick_q[i]  <= (cnt_nxt[i] == '0);
                end else begin
                    cnt[i]     <= '0;
                    div_q[i]   <= 1'b0;
                    tick_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign CK_DIV      = div_q;
    assign CK_TICK     = tick_q;
    assign BYPASS_SEL  = act_en & act_byp;
    assign CFG_PENDING = pend;
    assign RUNNING     = run;

endmodule

// File: tb/tb_pll_post_scaler_bank.sv
// Directed bench for pll_post_scaler_bank (NCH=3 so an out-of-range channel index exists).
module tb_pll_post_scaler_bank;
    localparam int NCH = 3;
    localparam int L2W = 8;
    localparam int CHW = 2;

    logic           CK = 1'b0;
    logic           RST;
    logic           CFG_WE;
    logic [CHW-1:0] CFG_CH;
    logic           CFG_EN;
    logic           CFG_BYPASS;
    logic [1:0]     CFG_L1;
    logic [L2W-1:0] CFG_L2;
    logic           SYNC;
    logic [NCH-1:0] CK_DIV, CK_TICK, BYPASS_SEL, CFG_PENDING, RUNNING;

    int n_checks = 0;
    int n_fail   = 0;

    pll_post_scaler_bank #(.NCH(NCH), .L2W(L2W)) dut (
        .CK(CK), .RST(RST), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_EN(CFG_EN),
        .CFG_BYPASS(CFG_BYPASS), .CFG_L1(CFG_L1), .CFG_L2(CFG_L2), .SYNC(SYNC),
        .CK_DIV(CK_DIV), .CK_TICK(CK_TICK), .BYPASS_SEL(BYPASS_SEL),
        .CFG_PENDING(CFG_PENDING), .RUNNING(RUNNING)
    );

    always #5 CK = ~CK;

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic wr(input int ch, input logic en, input logic byp, input int l1, input int l2);
        CFG_CH = CHW'(ch); CFG_EN = en; CFG_BYPASS = byp;
        CFG_L1 = 2'(l1); CFG_L2 = L2W'(l2); CFG_WE = 1'b1;
        step();
        CFG_WE = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1; CFG_WE = 1'b0; SYNC = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; SYNC = 1'b0;
        CFG_CH = '0; CFG_EN = 1'b1; CFG_BYPASS = 1'b0; CFG_L1 = 2'd1; CFG_L2 = 8'd3; CFG_WE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if ({CK_DIV, CK_TICK, BYPASS_SEL, CFG_PENDING, RUNNING} !== '0) begin n_fail++; $display("FAIL reset_outputs cyc%0d: got %0h expected 0", c, {CK_DIV, CK_TICK, BYPASS_SEL, CFG_PENDING, RUNNING}); end
        end
        RST = 1'b0; CFG_WE = 1'b0;
        step(); step();
        n_checks++; if (RUNNING !== 3'b000) begin n_fail++; $display("FAIL reset_running: got %b expected 000", RUNNING); end
        n_checks++; if (CK_TICK !== 3'b000) begin n_fail++; $display("FAIL reset_tick: got %b expected 000", CK_TICK); end
    endtask

    task automatic test_basic_divide();
        do_reset();
        wr(0, 1'b1, 1'b0, 1, 3);
        n_checks++; if (CFG_PENDING[0] !== 1'b1) begin n_fail++; $display("FAIL basic_pending: got %b expected 1", CFG_PENDING[0]); end
        n_checks++; if (CK_TICK[0] !== 1'b0) begin n_fail++; $display("FAIL basic_early_tick: got %b expected 0", CK_TICK[0]); end
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++; if (CK_TICK[0] !== ((k % 6) == 0)) begin n_fail++; $display("FAIL basic_tick k%0d: got %b expected %b", k, CK_TICK[0], (k % 6) == 0); end
            n_checks++; if (CK_DIV[0] !== ((k % 6) < 3)) begin n_fail++; $display("FAIL basic_div k%0d: got %b expected %b", k, CK_DIV[0], (k % 6) < 3); end
        end
        n_checks++; if (RUNNING !== 3'b001) begin n_fail++; $display("FAIL basic_running: got %b expected 001", RUNNING); end
        n_checks++; if (CFG_PENDING !== 3'b000) begin n_fail++; $display("FAIL basic_pending_clear: got %b expected 000", CFG_PENDING); end
    endtask

    task automatic test_odd_divisors();
        int hi, per;
        do_reset();
        wr(1, 1'b1, 1'b0, 0, 5);
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++; if (CK_DIV[1] !== ((k % 5) < 3)) begin n_fail++; $display("FAIL odd5_div k%0d: got %b expected %b", k, CK_DIV[1], (k % 5) < 3); end
            n_checks++; if (CK_TICK[1] !== ((k % 5) == 0)) begin n_fail++; $display("FAIL odd5_tick k%0d: got %b expected %b", k, CK_TICK[1], (k % 5) == 0); end
        end
        do_reset();
        wr(2, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++; if ({CK_DIV[2], CK_TICK[2]} !== 2'b11) begin n_fail++; $display("FAIL d1_div_tick k%0d: got %b expected 11", k, {CK_DIV[2], CK_TICK[2]}); end
        end
        do_reset();
        wr(0, 1'b1, 1'b0, 3, 255);
        step();
        n_checks++; if ({CK_DIV[0], CK_TICK[0]} !== 2'b11) begin n_fail++; $display("FAIL d2040_start: got %b expected 11", {CK_DIV[0], CK_TICK[0]}); end
        hi = 1; per = 0;
        for (int c = 1; c <= 2100; c++) begin
            step();
            if (CK_TICK[0]) begin per = c; break; end
            hi += int'(CK_DIV[0]);
        end
        n_checks++; if (per !== 2040) begin n_fail++; $display("FAIL d2040_period: got %0d expected 2040", per); end
        n_checks++; if (hi !== 1020) begin n_fail++; $display("FAIL d2040_high: got %0d expected 1020", hi); end
    endtask

    task automatic test_midperiod_reconfig();
        logic [3:0] div6 = 4'b0001;
        do_reset();
        wr(0, 1'b1, 1'b0, 1, 3);
        step(); step();
        wr(0, 1'b1, 1'b0, 2, 1);
        // old D=6 period continues at cnt 2..5 with the new config pending
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (CFG_PENDING[0] !== 1'b1) begin n_fail++; $display("FAIL reconfig_pending k%0d: got %b expected 1", k, CFG_PENDING[0]); end
            n_checks++; if (CK_DIV[0] !== div6[k]) begin n_fail++; $display("FAIL reconfig_olddiv k%0d: got %b expected %b", k, CK_DIV[0], div6[k]); end
            step();
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (CK_DIV[0] !== ((k % 4) < 2)) begin n_fail++; $display("FAIL reconfig_d4div k%0d: got %b expected %b", k, CK_DIV[0], (k % 4) < 2); end
            n_checks++; if (CK_TICK[0] !== ((k % 4) == 0)) begin n_fail++; $display("FAIL reconfig_d4tick k%0d: got %b expected %b", k, CK_TICK[0], (k % 4) == 0); end
            n_checks++; if (CFG_PENDING[0] !== 1'b0) begin n_fail++; $display("FAIL reconfig_pendclr k%0d: got %b expected 0", k, CFG_PENDING[0]); end
            if (k < 7) step();
        end
        wr(0, 1'b0, 1'b0, 2, 1);
        n_checks++; if ({CK_TICK[0], RUNNING[0], CFG_PENDING[0]} !== 3'b111) begin n_fail++; $display("FAIL disable_start: got %b expected 111", {CK_TICK[0], RUNNING[0], CFG_PENDING[0]}); end
        for (int k = 1; k < 4; k++) begin
            step();
            n_checks++; if (CK_DIV[0] !== (k < 2)) begin n_fail++; $display("FAIL disable_finish k%0d: got %b expected %b", k, CK_DIV[0], k < 2); end
        end
        step();
        n_checks++; if ({CK_DIV[0], CK_TICK[0], RUNNING[0], CFG_PENDING[0]} !== 4'b0000) begin n_fail++; $display("FAIL disable_parked: got %b expected 0000", {CK_DIV[0], CK_TICK[0], RUNNING[0], CFG_PENDING[0]}); end
        step();
        n_checks++; if (CK_DIV[0] !== 1'b0) begin n_fail++; $display("FAIL disable_stays_low: got %b expected 0", CK_DIV[0]); end
    endtask

    task automatic test_sync();
        do_reset();
        wr(0, 1'b1, 1'b0, 1, 3);
        step(); step();
        wr(1, 1'b1, 1'b0, 2, 1);
        step(); step();
        // ch0 at cnt 4, ch1 at cnt 1: phases differ
        n_checks++; if (CK_TICK[1:0] !== 2'b00) begin n_fail++; $display("FAIL sync_pre: got %b expected 00", CK_TICK[1:0]); end
        SYNC = 1'b1;
        wr(0, 1'b1, 1'b0, 1, 1);
        SYNC = 1'b0;
        n_checks++; if (CK_TICK[1:0] !== 2'b11) begin n_fail++; $display("FAIL sync_align: got %b expected 11", CK_TICK[1:0]); end
        n_checks++; if (CFG_PENDING[0] !== 1'b1) begin n_fail++; $display("FAIL sync_write_pending: got %b expected 1", CFG_PENDING[0]); end
        for (int k = 1; k < 6; k++) begin
            step();
            n_checks++; if (CK_TICK[1:0] !== {k % 4 == 0, 1'b0}) begin n_fail++; $display("FAIL sync_periodic k%0d: got %b expected %b", k, CK_TICK[1:0], {k % 4 == 0, 1'b0}); end
            n_checks++; if (CFG_PENDING[0] !== 1'b1) begin n_fail++; $display("FAIL sync_still_pending k%0d: got %b expected 1", k, CFG_PENDING[0]); end
        end
        step();
        n_checks++; if ({CK_TICK[0], CFG_PENDING[0]} !== 2'b10) begin n_fail++; $display("FAIL sync_late_apply: got %b expected 10", {CK_TICK[0], CFG_PENDING[0]}); end
        step();
        n_checks++; if ({CK_DIV[0], CK_TICK[0]} !== 2'b00) begin n_fail++; $display("FAIL sync_d2_low: got %b expected 00", {CK_DIV[0], CK_TICK[0]}); end
        step();
        n_checks++; if ({CK_DIV[0], CK_TICK[0]} !== 2'b11) begin n_fail++; $display("FAIL sync_d2_tick: got %b expected 11", {CK_DIV[0], CK_TICK[0]}); end
    endtask

    task automatic test_bypass_misc();
        do_reset();
        wr(0, 1'b1, 1'b0, 2, 1);
        step(); step();
        wr(0, 1'b1, 1'b1, 2, 1);
        n_checks++; if ({BYPASS_SEL[0], CFG_PENDING[0], RUNNING[0]} !== 3'b011) begin n_fail++; $display("FAIL bypass_wait: got %b expected 011", {BYPASS_SEL[0], CFG_PENDING[0], RUNNING[0]}); end
        step();
        n_checks++; if (BYPASS_SEL[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_midperiod: got %b expected 0", BYPASS_SEL[0]); end
        step();
        n_checks++; if ({BYPASS_SEL[0], CK_DIV[0], CK_TICK[0], RUNNING[0]} !== 4'b1000) begin n_fail++; $display("FAIL bypass_applied: got %b expected 1000", {BYPASS_SEL[0], CK_DIV[0], CK_TICK[0], RUNNING[0]}); end
        wr(3, 1'b1, 1'b0, 0, 2);
        step();
        n_checks++; if ({CFG_PENDING, RUNNING, BYPASS_SEL, CK_TICK} !== 12'b000_000_001_000) begin n_fail++; $display("FAIL bad_channel: got %b expected 000000001000", {CFG_PENDING, RUNNING, BYPASS_SEL, CK_TICK}); end
        wr(1, 1'b1, 1'b0, 1, 3);
        step(); step();
        wr(2, 1'b1, 1'b0, 0, 3);
        RST = 1'b1;
        step();
        n_checks++; if ({CK_DIV, CK_TICK, BYPASS_SEL, CFG_PENDING, RUNNING} !== '0) begin n_fail++; $display("FAIL midrun_reset: got %0h expected 0", {CK_DIV, CK_TICK, BYPASS_SEL, CFG_PENDING, RUNNING}); end
        RST = 1'b0;
        step(); step();
        n_checks++; if ({CK_TICK, RUNNING, CFG_PENDING} !== '0) begin n_fail++; $display("FAIL post_reset_idle: got %0h expected 0", {CK_TICK, RUNNING, CFG_PENDING}); end
    endtask

    initial begin
        RST = 1'b1; CFG_WE = 1'b0; CFG_CH = '0; CFG_EN = 1'b0; CFG_BYPASS = 1'b0;
        CFG_L1 = '0; CFG_L2 = '0; SYNC = 1'b0;
        test_reset();
        test_basic_divide();
        test_odd_divisors();
        test_midperiod_reconfig();
        test_sync();
        test_bypass_misc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
